// File: rtl/conware_board_streamer.sv
// Host-side AXI-Stream driver for the conware life engine.
// Holds a ROWS x 32-bit board, streams it out row by row, captures the returned
// next generation back into the same storage and repeats for GEN_COUNT generations.
module conware_board_streamer #(
    parameter int unsigned ROWS   = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              START,
    input  logic [15:0]       GEN_COUNT,
    input  logic              LOAD_EN,
    input  logic [ADDR_W-1:0] LOAD_ADDR,
    input  logic [31:0]       LOAD_DATA,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [31:0]       RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [15:0]       GEN_DONE,
    output logic              M_AXIS_TVALID,
    output logic [31:0]       M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic [3:0]        M_AXIS_TKEEP,
    output logic [3:0]        M_AXIS_TSTRB,
    output logic              S_AXIS_TREADY,
    input  logic [31:0]       S_AXIS_TDATA,
    input  logic              S_AXIS_TLAST,
    input  logic              S_AXIS_TVALID
);

    typedef enum logic [1:0] {StIdle, StSend, StRecv} state_e;

    localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(ROWS - 1);

    state_e            state_q, state_d;
    logic [31:0]       board_q [ROWS];
    logic [ADDR_W-1:0] ptr_q;
    logic [15:0]       gen_target_q;
    logic [15:0]       gen_done_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rd_data_q;

    logic at_last;
    logic m_hs;
    logic s_hs;
    logic frame_err;
    logic run_done;

    // Handshake decode and beat classification shared by FSM and datapath
    always_comb begin
        at_last   = (ptr_q == LastRow);
        m_hs      = (state_q == StSend) && M_AXIS_TREADY;
        s_hs      = (state_q == StRecv) && S_AXIS_TVALID;
        // TLAST must mark exactly the last row; early or missing TLAST aborts the run
        frame_err = s_hs && (S_AXIS_TLAST != at_last);
        run_done  = s_hs && at_last && S_AXIS_TLAST &&
                    ((gen_done_q + 16'd1) == gen_target_q);
    end

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (START && (GEN_COUNT != 16'd0)) state_d = StSend;
            end
            StSend: begin
                if (m_hs && at_last) state_d = StRecv;
            end
            StRecv: begin
                if (frame_err || run_done) begin
                    state_d = StIdle;
                end else if (s_hs && at_last) begin
                    state_d = StSend;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM-decoded stream outputs
    always_comb begin
        BUSY          = (state_q != StIdle);
        M_AXIS_TVALID = (state_q == StSend);
        M_AXIS_TDATA  = board_q[ptr_q];
        M_AXIS_TLAST  = (state_q == StSend) && at_last;
        S_AXIS_TREADY = (state_q == StRecv);
        M_AXIS_TKEEP  = 4'hF;
        M_AXIS_TSTRB  = 4'hF;
        RD_DATA       = rd_data_q;
        DONE          = done_q;
        ERR           = err_q;
        GEN_DONE      = gen_done_q;
    end

    // Board storage, row pointer, generation counter and status flags
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < int'(ROWS); i++) board_q[i] <= '0;
            ptr_q        <= '0;
            gen_target_q <= '0;
            gen_done_q   <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            rd_data_q <= board_q[RD_ADDR];
            done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (LOAD_EN) board_q[LOAD_ADDR] <= LOAD_DATA;
                    if (START) begin
                        err_q        <= 1'b0;
                        gen_done_q   <= '0;
                        ptr_q        <= '0;
                        gen_target_q <= GEN_COUNT;
                        if (GEN_COUNT == 16'd0) done_q <= 1'b1;
                    end
                end
                StSend: begin
                    if (m_hs) ptr_q <= at_last ? '0 : ptr_q + ADDR_W'(1);
                end
                StRecv: begin
                    if (s_hs) begin
                        // Safe in place: the whole board went out before the first row returns
                        board_q[ptr_q] <= S_AXIS_TDATA;
                        if (frame_err) begin
                            err_q  <= 1'b1;
                            done_q <= 1'b1;
                            ptr_q  <= '0;
                        end else if (at_last) begin
                            gen_done_q <= gen_done_q + 16'd1;
                            ptr_q      <= '0;
                            if (run_done) done_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conware_board_streamer.sv
// Directed bench for conware_board_streamer; a behavioural life-engine partner
// answers each streamed board with its next generation (dead cells beyond the edges).
module tb_conware_board_streamer;

    localparam int ROWS = 32;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        START = 1'b0;
    logic [15:0] GEN_COUNT = '0;
    logic        LOAD_EN = 1'b0;
    logic [4:0]  LOAD_ADDR = '0;
    logic [31:0] LOAD_DATA = '0;
    logic [4:0]  RD_ADDR = '0;
    logic [31:0] RD_DATA;
    logic        BUSY, DONE, ERR;
    logic [15:0] GEN_DONE;
    logic        M_AXIS_TVALID, M_AXIS_TLAST;
    logic [31:0] M_AXIS_TDATA;
    logic        M_AXIS_TREADY = 1'b0;
    logic [3:0]  M_AXIS_TKEEP, M_AXIS_TSTRB;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA = '0;
    logic        S_AXIS_TLAST = 1'b0;
    logic        S_AXIS_TVALID = 1'b0;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_board [ROWS];
    logic [31:0] resp [ROWS];

    conware_board_streamer #(.ROWS(ROWS), .ADDR_W(5)) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .START         (START),
        .GEN_COUNT     (GEN_COUNT),
        .LOAD_EN       (LOAD_EN),
        .LOAD_ADDR     (LOAD_ADDR),
        .LOAD_DATA     (LOAD_DATA),
        .RD_ADDR       (RD_ADDR),
        .RD_DATA       (RD_DATA),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERR           (ERR),
        .GEN_DONE      (GEN_DONE),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TKEEP  (M_AXIS_TKEEP),
        .M_AXIS_TSTRB  (M_AXIS_TSTRB),
        .S_AXIS_TREADY (S_AXIS_TREADY),
        .S_AXIS_TDATA  (S_AXIS_TDATA),
        .S_AXIS_TLAST  (S_AXIS_TLAST),
        .S_AXIS_TVALID (S_AXIS_TVALID)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_row(input int a, input logic [31:0] d);
        LOAD_EN = 1'b1;
        LOAD_ADDR = a[4:0];
        LOAD_DATA = d;
        exp_board[a] = d;
        tick();
        LOAD_EN = 1'b0;
    endtask

    task automatic read_row(input int a, output logic [31:0] d);
        RD_ADDR = a[4:0];
        tick();
        d = RD_DATA;
    endtask

    task automatic check_board(input string tag);
        logic [31:0] d;
        for (int i = 0; i < ROWS; i++) begin
            read_row(i, d);
            check($sformatf("%s_row%0d", tag, i), d, exp_board[i]);
        end
    endtask

    // Next generation of exp_board into resp
    task automatic life_step();
        int n;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < 32; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS &&
                            c + dc >= 0 && c + dc < 32) begin
                            n += int'(exp_board[r + dr][c + dc]);
                        end
                    end
                end
                resp[r][c] = (n == 3) || (exp_board[r][c] && n == 2);
            end
        end
    endtask

    // One full run; err_beat >= 0 plants an early TLAST, poke issues START/LOAD_EN mid-SEND
    task automatic run(input int gens, input int err_beat, input bit bp, input bit poke);
        int beat, cyc;
        logic [31:0] held;
        bit stalled, fin;
        GEN_COUNT = gens[15:0];
        START = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", BUSY, 1);
        check("tvalid_after_start", M_AXIS_TVALID, 1);
        for (int g = 0; g < gens; g++) begin
            beat = 0; cyc = 0; stalled = 0; held = '0;
            while (beat < ROWS && cyc < 2000) begin
                if (stalled) check("tdata_stable", M_AXIS_TDATA, held);
                M_AXIS_TREADY = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (poke && g == 0 && cyc == 3) begin
                    START = 1'b1; LOAD_EN = 1'b1; LOAD_ADDR = 5'd0; LOAD_DATA = 32'hDEAD_BEEF;
                end else begin
                    START = 1'b0; LOAD_EN = 1'b0;
                end
                if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                    check($sformatf("m_tdata_g%0d_b%0d", g, beat), M_AXIS_TDATA, exp_board[beat]);
                    check($sformatf("m_tlast_b%0d", beat), M_AXIS_TLAST, beat == ROWS - 1);
                    beat++;
                    stalled = 0;
                end else begin
                    stalled = M_AXIS_TVALID;
                    held = M_AXIS_TDATA;
                end
                tick();
                cyc++;
            end
            START = 1'b0; LOAD_EN = 1'b0; M_AXIS_TREADY = 1'b0;
            if (beat < ROWS) begin
                check("send_timeout", beat, ROWS);
                return;
            end
            check("send_end_tvalid", M_AXIS_TVALID, 0);
            check("send_end_s_tready", S_AXIS_TREADY, 1);
            life_step();
            beat = 0; cyc = 0; fin = 0;
            while (!fin && cyc < 2000) begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA = resp[beat];
                S_AXIS_TLAST = (err_beat >= 0) ? (beat == err_beat) : (beat == ROWS - 1);
                if (S_AXIS_TREADY) begin
                    exp_board[beat] = resp[beat];
                    fin = S_AXIS_TLAST;
                    beat++;
                end
                tick();
                cyc++;
            end
            S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
            if (!fin) begin
                check("recv_timeout", beat, ROWS);
                return;
            end
            if (err_beat >= 0) begin
                check("err_set", ERR, 1);
                check("err_done", DONE, 1);
                check("err_busy", BUSY, 0);
                check("err_gen_done", GEN_DONE, 0);
                tick();
                check("err_done_pulse", DONE, 0);
                return;
            end
            if (g == gens - 1) begin
                check("final_done", DONE, 1);
                check("final_busy", BUSY, 0);
                check("final_gen_done", GEN_DONE, gens);
                check("final_err", ERR, 0);
                tick();
                check("final_done_pulse", DONE, 0);
            end else begin
                check("mid_s_tready", S_AXIS_TREADY, 0);
                check("mid_m_tvalid", M_AXIS_TVALID, 1);
                check("mid_gen_done", GEN_DONE, g + 1);
                check("mid_done", DONE, 0);
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        int beat, cyc;

        for (int i = 0; i < ROWS; i++) exp_board[i] = '0;

        // Reset state
        tick();
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_gen_done", GEN_DONE, 0);
        check("rst_m_tvalid", M_AXIS_TVALID, 0);
        check("rst_m_tlast", M_AXIS_TLAST, 0);
        check("rst_s_tready", S_AXIS_TREADY, 0);
        check("rst_tkeep", M_AXIS_TKEEP, 4'hF);
        check("rst_tstrb", M_AXIS_TSTRB, 4'hF);
        check("rst_rd_data", RD_DATA, 0);
        ARESET = 1'b0;

        // Load and readback
        for (int i = 0; i < ROWS; i++) begin
            load_row(i, 32'hA5A5_0000 + i);
            check("load_tvalid", M_AXIS_TVALID, 0);
        end
        check_board("load");

        // GEN_COUNT = 0: immediate DONE, no traffic
        GEN_COUNT = 16'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("gen0_done", DONE, 1);
        check("gen0_busy", BUSY, 0);
        check("gen0_tvalid", M_AXIS_TVALID, 0);
        check("gen0_gen_done", GEN_DONE, 0);
        tick();
        check("gen0_done_pulse", DONE, 0);

        // Backpressure on the M side, one generation
        run(1, -1, 1'b1, 1'b0);
        check_board("bp");

        // Framing error: early TLAST on beat 5
        run(3, 5, 1'b0, 1'b0);
        check_board("ferr");
        check("ferr_sticky", ERR, 1);
        GEN_COUNT = 16'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("ferr_cleared", ERR, 0);
        check("ferr_clr_done", DONE, 1);

        // Blinker, two generations, with ignored mid-run START/LOAD_EN
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        for (int i = 0; i < ROWS; i++) exp_board[i] = '0;
        load_row(10, 32'h100);
        load_row(11, 32'h100);
        load_row(12, 32'h100);
        run(2, -1, 1'b0, 1'b1);
        check_board("blink2");
        read_row(10, d); check("blink2_r10", d, 32'h100);
        read_row(11, d); check("blink2_r11", d, 32'h100);
        read_row(12, d); check("blink2_r12", d, 32'h100);
        read_row(0, d);  check("blink2_r0_untouched", d, 32'h0);
        tick();
        check("blink2_no_extra_done", DONE, 0);
        check("blink2_idle", BUSY, 0);

        // Blinker, one generation
        run(1, -1, 1'b0, 1'b0);
        read_row(10, d); check("blink1_r10", d, 32'h0);
        read_row(11, d); check("blink1_r11", d, 32'h380);
        read_row(12, d); check("blink1_r12", d, 32'h0);

        // Reset during SEND beat 7
        M_AXIS_TREADY = 1'b1;
        GEN_COUNT = 16'd1;
        START = 1'b1;
        tick();
        START = 1'b0;
        beat = 0; cyc = 0;
        while (beat < 7 && cyc < 100) begin
            if (M_AXIS_TVALID) beat++;
            tick();
            cyc++;
        end
        check("arst_reach_beat7", beat, 7);
        ARESET = 1'b1;
        tick();
        check("arst_tvalid", M_AXIS_TVALID, 0);
        check("arst_busy", BUSY, 0);
        check("arst_done", DONE, 0);
        check("arst_s_tready", S_AXIS_TREADY, 0);
        ARESET = 1'b0;
        M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < ROWS; i++) exp_board[i] = '0;
        check_board("arst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
